// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone definitions: bus widths, master indices, cycle/burst type
// encodings and the arbiter state type.
package wbPkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = WB_DW / 8;
    localparam int WB_CTIW = 3;
    localparam int WB_BTEW = 2;

    localparam int WB_NUM_MASTER     = 3;
    localparam int WB_MASTER_DU      = 0;
    localparam int WB_MASTER_CPU     = 1;
    localparam int WB_MASTER_BINLOAD = 2;

    localparam int WB_ARB_TIMEOUT_CYC = 255;

    localparam logic [WB_CTIW-1:0] WB_CTI_CLASSIC      = 3'b000;
    localparam logic [WB_CTIW-1:0] WB_CTI_CONST        = 3'b001;
    localparam logic [WB_CTIW-1:0] WB_CTI_INC_BURST    = 3'b010;
    localparam logic [WB_CTIW-1:0] WB_CTI_END_OF_BURST = 3'b111;

    localparam logic [WB_BTEW-1:0] WB_BTE_LINEAR = 2'b00;
    localparam logic [WB_BTEW-1:0] WB_BTE_WRAP_4 = 2'b01;
    localparam logic [WB_BTEW-1:0] WB_BTE_WRAP_8 = 2'b10;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } wbArbState_t;

    // Index width that stays legal for a single-master build.
    function automatic int wb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_picker.sv
// Round-robin first-one finder: scans from last_idx+1 upward, wrapping,
// and returns the first requester as one-hot plus its index.
module wb_rr_picker
    import wbPkg::*;
#(
    parameter int NUM_MASTER = WB_NUM_MASTER,
    parameter int IDX_W      = wb_idx_w(NUM_MASTER)
) (
    input  logic [NUM_MASTER-1:0] req,
    input  logic [IDX_W-1:0]      last_idx,
    output logic [NUM_MASTER-1:0] pick,
    output logic [IDX_W-1:0]      pick_idx
);

    logic found;
    int   cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NUM_MASTER; i++) begin
            cand = (int'(last_idx) + i) % NUM_MASTER;
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone arbiter: locks the bus to one master per cyc, muxes
// its signals onto the shared bus and times out strobes the slave ignores.
module wb_master_arbiter
    import wbPkg::*;
#(
    parameter int NUM_MASTER  = WB_NUM_MASTER,
    parameter int TIMEOUT_CYC = WB_ARB_TIMEOUT_CYC,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_MASTER-1:0]         m_cyc_i,
    input  logic [NUM_MASTER-1:0]         m_stb_i,
    input  logic [NUM_MASTER-1:0]         m_we_i,
    input  logic [NUM_MASTER*WB_AW-1:0]   m_adr_i,
    input  logic [NUM_MASTER*WB_DW-1:0]   m_dat_i,
    input  logic [NUM_MASTER*WB_SELW-1:0] m_sel_i,
    input  logic [NUM_MASTER*WB_CTIW-1:0] m_cti_i,
    input  logic [NUM_MASTER*WB_BTEW-1:0] m_bte_i,
    output logic [NUM_MASTER-1:0]         m_ack_o,
    output logic [NUM_MASTER-1:0]         m_err_o,
    output logic [WB_DW-1:0]              m_dat_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [WB_AW-1:0]              s_adr_o,
    output logic [WB_DW-1:0]              s_dat_o,
    output logic [WB_SELW-1:0]            s_sel_o,
    output logic [WB_CTIW-1:0]            s_cti_o,
    output logic [WB_BTEW-1:0]            s_bte_o,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic [WB_DW-1:0]              s_dat_i,
    output logic [NUM_MASTER-1:0]         gnt_o,
    output logic                          busy_o,
    output logic                          wdt_fire_o
);

    localparam int IDX_W = wb_idx_w(NUM_MASTER);

    wbArbState_t           state_q, state_d;
    logic [NUM_MASTER-1:0] gnt_d, pick;
    logic [IDX_W-1:0]      last_idx, last_idx_d, pick_idx;
    logic [CNT_W-1:0]      wdt_cnt;
    logic                  wdt_pending;

    wb_rr_picker #(
        .NUM_MASTER (NUM_MASTER),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req      (m_cyc_i),
        .last_idx (last_idx),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ARB_IDLE;
            gnt_o    <= '0;
            last_idx <= IDX_W'(NUM_MASTER - 1);
        end else begin
            state_q  <= state_d;
            gnt_o    <= gnt_d;
            last_idx <= last_idx_d;
        end
    end

    // Arbitration only happens from IDLE, so an owner keeps the bus for its whole cyc.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_o;
        last_idx_d = last_idx;
        case (state_q)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    state_d    = ARB_OWNED;
                    gnt_d      = pick;
                    last_idx_d = pick_idx;
                end
            end
            ARB_OWNED: begin
                if (!s_cyc_o) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign busy_o  = (state_q == ARB_OWNED);
    assign s_cyc_o = |(m_cyc_i & gnt_o);
    assign s_stb_o = s_cyc_o & |(m_stb_i & gnt_o);
    assign s_we_o  = |(m_we_i & gnt_o);
    assign m_dat_o = s_dat_i;
    assign m_ack_o = gnt_o & {NUM_MASTER{s_ack_i & s_stb_o}};
    assign m_err_o = gnt_o & {NUM_MASTER{(s_err_i & s_stb_o) | wdt_fire_o}};

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (gnt_o[i]) begin
                s_adr_o = m_adr_i[i*WB_AW   +: WB_AW];
                s_dat_o = m_dat_i[i*WB_DW   +: WB_DW];
                s_sel_o = m_sel_i[i*WB_SELW +: WB_SELW];
                s_cti_o = m_cti_i[i*WB_CTIW +: WB_CTIW];
                s_bte_o = m_bte_i[i*WB_BTEW +: WB_BTEW];
            end
        end
    end

    // The fire cycle itself terminates the strobe, so it restarts the count.
    assign wdt_pending = s_stb_o & ~s_ack_i & ~s_err_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdt_cnt    <= '0;
            wdt_fire_o <= 1'b0;
        end else begin
            wdt_fire_o <= 1'b0;
            if (!wdt_pending || wdt_fire_o || state_q == ARB_IDLE) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                wdt_cnt    <= '0;
                wdt_fire_o <= 1'b1;
            end else begin
                wdt_cnt <= wdt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: grant order, burst locking,
// watchdog timeout, reset mid-burst and owner abort.
module tb_wb_master_arbiter;
    import wbPkg::*;

    localparam int NM = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*32-1:0]  m_adr, m_dat;
    logic [NM*4-1:0]   m_sel;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [NM-1:0]     m_ack, m_err;
    logic [31:0]       m_dat_o;
    logic              s_cyc, s_stb, s_we;
    logic [31:0]       s_adr, s_dat_o;
    logic [3:0]        s_sel;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_ack, s_err;
    logic [31:0]       s_dat_i;
    logic [NM-1:0]     gnt;
    logic              busy, wdt_fire;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .NUM_MASTER  (NM),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_dat),
        .m_sel_i    (m_sel),
        .m_cti_i    (m_cti),
        .m_bte_i    (m_bte),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .m_dat_o    (m_dat_o),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel),
        .s_cti_o    (s_cti),
        .s_bte_o    (s_bte),
        .s_ack_i    (s_ack),
        .s_err_i    (s_err),
        .s_dat_i    (s_dat_i),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .wdt_fire_o (wdt_fire)
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive_m(input int i, input logic cyc, input logic stb,
                           input logic [31:0] adr, input logic [2:0] cti,
                           input logic [1:0] bte);
        m_cyc[i]         = cyc;
        m_stb[i]         = stb;
        m_adr[i*32 +: 32] = adr;
        m_cti[i*3 +: 3]   = cti;
        m_bte[i*2 +: 2]   = bte;
    endtask

    task automatic do_reset;
        nxt;
        rstn = 1'b0;
        nxt;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        smp;
        n_cmp++;
        if ({gnt, busy, s_cyc, s_stb, s_we, wdt_fire, m_ack, m_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, busy, s_cyc, s_stb, s_we, wdt_fire, m_ack, m_err});
        end
        n_cmp++;
        if ({s_adr, s_dat_o, s_sel, s_cti, s_bte} !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0", {s_adr, s_dat_o, s_sel, s_cti, s_bte});
        end
        nxt;
        rstn = 1'b1;
        smp;
        n_cmp++;
        if ({gnt, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_release_idle: got %b want 0000", {gnt, busy});
        end
    endtask

    task automatic test_single;
        nxt;
        drive_m(1, 1'b1, 1'b1, 32'h0010_0004, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        m_sel[4 +: 4] = 4'hF;
        smp;
        n_cmp++;
        if ({gnt, s_cyc} !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pre_grant: got %b want 0000", {gnt, s_cyc});
        end
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_bad++;
            $display("FAIL single_gnt: got %b want 010", gnt);
        end
        n_cmp++;
        if (s_adr !== 32'h0010_0004) begin
            n_bad++;
            $display("FAIL single_adr: got %h want 00100004", s_adr);
        end
        n_cmp++;
        if ({s_cyc, s_stb, busy, s_sel, m_ack} !== {3'b111, 4'hF, 3'b000}) begin
            n_bad++;
            $display("FAIL single_bus: got %b want 1111111000", {s_cyc, s_stb, busy, s_sel, m_ack});
        end
        nxt;
        smp;
        n_cmp++;
        if (m_ack !== 3'b000) begin
            n_bad++;
            $display("FAIL single_wait_ack: got %b want 000", m_ack);
        end
        nxt;
        s_ack   = 1'b1;
        s_dat_i = 32'h1234_5678;
        smp;
        n_cmp++;
        if (m_ack !== 3'b010) begin
            n_bad++;
            $display("FAIL single_ack: got %b want 010", m_ack);
        end
        n_cmp++;
        if (m_dat_o !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL single_rdata: got %h want 12345678", m_dat_o);
        end
        nxt;
        s_ack = 1'b0;
        drive_m(1, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        smp;
        n_cmp++;
        if ({m_ack, s_cyc, gnt} !== 7'b000_0_010) begin
            n_bad++;
            $display("FAIL single_release: got %b want 0000010", {m_ack, s_cyc, gnt});
        end
        nxt;
        smp;
        n_cmp++;
        if ({gnt, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_idle: got %b want 0000", {gnt, busy});
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_g;
        do_reset;
        for (int i = 0; i < NM; i++)
            drive_m(i, 1'b1, 1'b1, 32'h1000 + 32'(i), WB_CTI_CLASSIC, WB_BTE_LINEAR);
        smp;
        for (int k = 0; k < NM; k++) begin
            exp_g = 3'b001 << k;
            nxt;
            s_ack = 1'b1;
            smp;
            n_cmp++;
            if ({gnt, m_ack} !== {exp_g, exp_g}) begin
                n_bad++;
                $display("FAIL rr_grant_%0d: got gnt/ack %b want %b", k, {gnt, m_ack}, {exp_g, exp_g});
            end
            nxt;
            s_ack = 1'b0;
            drive_m(k, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
            smp;
            n_cmp++;
            if (s_cyc !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_drop_%0d: got s_cyc %b want 0", k, s_cyc);
            end
            nxt;
            smp;
            n_cmp++;
            if (gnt !== 3'b000) begin
                n_bad++;
                $display("FAIL rr_idle_gap_%0d: got %b want 000", k, gnt);
            end
        end
        nxt;
        drive_m(0, 1'b1, 1'b1, 32'h2000, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        drive_m(1, 1'b1, 1'b1, 32'h2004, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        smp;
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b001) begin
            n_bad++;
            $display("FAIL rr_wrap: got %b want 001", gnt);
        end
        nxt;
        drive_m(0, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        drive_m(1, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL rr_wrap_release: got %b want 000", gnt);
        end
    endtask

    task automatic test_burst;
        logic [2:0] cti;
        nxt;
        drive_m(2, 1'b1, 1'b1, 32'h200, WB_CTI_INC_BURST, WB_BTE_WRAP_4);
        drive_m(0, 1'b1, 1'b1, 32'h300, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) nxt;
            cti = (b == 3) ? WB_CTI_END_OF_BURST : WB_CTI_INC_BURST;
            drive_m(2, 1'b1, 1'b1, 32'h200 + 32'(4 * b), cti, WB_BTE_WRAP_4);
            s_ack = 1'b1;
            smp;
            n_cmp++;
            if ({gnt, m_ack, s_cti, s_bte} !== {3'b100, 3'b100, cti, WB_BTE_WRAP_4}) begin
                n_bad++;
                $display("FAIL burst_beat_%0d: got gnt/ack/cti/bte %b want %b", b,
                         {gnt, m_ack, s_cti, s_bte}, {3'b100, 3'b100, cti, WB_BTE_WRAP_4});
            end
        end
        nxt;
        s_ack = 1'b0;
        drive_m(2, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        smp;
        n_cmp++;
        if ({gnt, s_cyc} !== 4'b100_0) begin
            n_bad++;
            $display("FAIL burst_drop: got %b want 1000", {gnt, s_cyc});
        end
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL burst_idle: got %b want 000", gnt);
        end
        nxt;
        smp;
        n_cmp++;
        if ({gnt, s_adr} !== {3'b001, 32'h300}) begin
            n_bad++;
            $display("FAIL burst_next_owner: got %h want %h", {gnt, s_adr}, {3'b001, 32'h300});
        end
        nxt;
        drive_m(0, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
    endtask

    task automatic test_watchdog;
        logic [3:0] exp_w;
        nxt;
        drive_m(1, 1'b1, 1'b1, 32'hDEAD_0000, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) nxt;
            smp;
            exp_w = (c == 9) ? 4'b1_010 : 4'b0_000;
            n_cmp++;
            if ({wdt_fire, m_err} !== exp_w) begin
                n_bad++;
                $display("FAIL wdt_cycle_%0d: got %b want %b", c, {wdt_fire, m_err}, exp_w);
            end
        end
        nxt;
        drive_m(1, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        smp;
        n_cmp++;
        if ({wdt_fire, m_err, s_cyc} !== 5'b0) begin
            n_bad++;
            $display("FAIL wdt_after: got %b want 00000", {wdt_fire, m_err, s_cyc});
        end
        nxt;
        smp;
        n_cmp++;
        if ({gnt, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL wdt_idle: got %b want 0000", {gnt, busy});
        end
    endtask

    task automatic test_reset_mid_burst;
        nxt;
        drive_m(2, 1'b1, 1'b1, 32'h400, WB_CTI_INC_BURST, WB_BTE_WRAP_4);
        nxt;
        s_ack = 1'b1;
        smp;
        n_cmp++;
        if (gnt !== 3'b100) begin
            n_bad++;
            $display("FAIL rstmid_beat1: got %b want 100", gnt);
        end
        nxt;
        drive_m(2, 1'b1, 1'b1, 32'h404, WB_CTI_INC_BURST, WB_BTE_WRAP_4);
        smp;
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({s_cyc, gnt, m_ack, busy} !== 8'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b want 00000000", {s_cyc, gnt, m_ack, busy});
        end
        s_ack = 1'b0;
        drive_m(1, 1'b1, 1'b1, 32'h500, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
        rstn = 1'b1;
        smp;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid_release: got %b want 000", gnt);
        end
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_bad++;
            $display("FAIL rstmid_regrant: got %b want 010", gnt);
        end
        nxt;
        drive_m(1, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        drive_m(2, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
    endtask

    task automatic test_abort;
        nxt;
        drive_m(2, 1'b1, 1'b1, 32'h600, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        drive_m(0, 1'b1, 1'b1, 32'h700, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
        smp;
        n_cmp++;
        if ({gnt, s_stb} !== 4'b100_1) begin
            n_bad++;
            $display("FAIL abort_owner: got %b want 1001", {gnt, s_stb});
        end
        nxt;
        m_cyc[2] = 1'b0;
        smp;
        n_cmp++;
        if ({s_cyc, s_stb, m_err, wdt_fire} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_drop: got %b want 000000", {s_cyc, s_stb, m_err, wdt_fire});
        end
        nxt;
        smp;
        n_cmp++;
        if ({gnt, wdt_fire, m_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got %b want 0000000", {gnt, wdt_fire, m_err});
        end
        nxt;
        smp;
        n_cmp++;
        if (gnt !== 3'b001) begin
            n_bad++;
            $display("FAIL abort_next: got %b want 001", gnt);
        end
        nxt;
        m_stb[2] = 1'b0;
        drive_m(0, 1'b0, 1'b0, 32'h0, WB_CTI_CLASSIC, WB_BTE_LINEAR);
        nxt;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: still running at %0t, required to end earlier", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn    = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat   = '0;
        m_sel   = '0;
        m_cti   = '0;
        m_bte   = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_i = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_burst;
        test_watchdog;
        test_reset_mid_burst;
        test_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
